// File: rtl/sdram_req_arbiter_if.sv
// rtl/sdram_req_arbiter_if.sv - simple SDRAM request/response port bundle
//
// One requester-to-controller request port. The same bundle is used for
// both requester ports and for the controller-side port of the arbiter.
//
// Signals:
//   wr      4   byte write strobes, nonzero means write request
//   rd      1   read request
//   addr    32  request byte address
//   wdata   32  write data
//   accept  1   request taken this cycle
//   ack     1   response strobe
//   error   1   response error, valid with ack
//   rdata   32  read data, valid with ack
//
// Modports:
//   master  issues requests (drives wr/rd/addr/wdata, receives the rest)
//   slave   serves requests (receives wr/rd/addr/wdata, drives the rest)
interface sdram_req_arbiter_if;
  logic [3:0]  wr;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        accept;
  logic        ack;
  logic        error;
  logic [31:0] rdata;

  modport master (
    output wr,
    output rd,
    output addr,
    output wdata,
    input  accept,
    input  ack,
    input  error,
    input  rdata
  );

  modport slave (
    input  wr,
    input  rd,
    input  addr,
    input  wdata,
    output accept,
    output ack,
    output error,
    output rdata
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - two-requester round-robin arbiter for the SDRAM controller request port
//
// Shares one SDRAM controller request port between requester 0 (CPU bus
// adapter) and requester 1 (DMA/display). Grant is round-robin between
// simultaneous requesters; once a request is presented and not yet taken
// by the controller the grant is locked to it. An in-order ID FIFO steers
// each controller response back to the requester that issued it. The
// request path is purely combinational, adding no latency.
//
// Ports:
//   clock         single clock for all state
//   reset         synchronous, active-high reset
//   m0            requester 0 port (slave side of the bundle)
//   m1            requester 1 port (slave side of the bundle)
//   out           controller port (master side of the bundle)
//   outstanding   current ID FIFO occupancy
//   spurious_ack  sticky: controller ack arrived with nothing outstanding
module sdram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  sdram_req_arbiter_if.slave   m0,
  sdram_req_arbiter_if.slave   m1,
  sdram_req_arbiter_if.master  out,
  output logic [CNT_W:0]       outstanding,
  output logic                 spurious_ack
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W:0] MAX_CNT  = (CNT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t state_q, state_d;
  logic        locked_id_q, locked_id_d;
  logic        prio_q, prio_d;

  logic        req0, req1;
  logic        grant_valid;
  logic        grant_id;
  logic        fifo_full, fifo_empty;
  logic        fwd;
  logic        fire;
  logic        push, pop;
  logic        head_id;

  logic             fifo_id [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign req0 = m0.rd | (|m0.wr);
  assign req1 = m1.rd | (|m1.wr);

  assign fifo_full  = (outstanding == MAX_CNT);
  assign fifo_empty = (outstanding == '0);

  // Grant selection. While locked the latched requester keeps the grant
  // even if its request has (illegally) dropped.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = prio_q;
    if (state_q == ST_LOCKED) begin
      grant_valid = 1'b1;
      grant_id    = locked_id_q;
    end else if (req0 && req1) begin
      grant_valid = 1'b1;
      grant_id    = prio_q;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // A full FIFO blocks forwarding even when an ack pops it this cycle;
  // the freed slot becomes usable next cycle.
  assign fwd  = grant_valid & ~fifo_full & ~reset;
  assign fire = fwd & out.accept;

  // Controller-side request mux. Address and data follow the grant even
  // when nothing is forwarded; only the command strobes are qualified.
  always_comb begin
    out.addr  = grant_id ? m1.addr  : m0.addr;
    out.wdata = grant_id ? m1.wdata : m0.wdata;
    out.wr    = '0;
    out.rd    = 1'b0;
    if (fwd) begin
      out.wr = grant_id ? m1.wr : m0.wr;
      out.rd = grant_id ? m1.rd : m0.rd;
    end
  end

  assign m0.accept = fire & ~grant_id;
  assign m1.accept = fire &  grant_id;

  // Lock / round-robin state machine.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_OPEN;
      locked_id_q <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_id_q <= locked_id_d;
      prio_q      <= prio_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    locked_id_d = locked_id_q;
    prio_d      = prio_q;
    if (fwd && !out.accept) begin
      // Presented but not taken: pin the grant so the request stays put.
      state_d     = ST_LOCKED;
      locked_id_d = grant_id;
    end else if (fire) begin
      state_d = ST_OPEN;
      prio_d  = ~grant_id;
    end
    // Full while locked leaves fwd low, so the lock is simply held.
  end

  // In-order ID FIFO: one entry per accepted request awaiting its ack.
  assign push    = fire;
  assign pop     = out.ack & ~fifo_empty & ~reset;
  assign head_id = fifo_id[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_id[wr_ptr] <= grant_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
      spurious_ack <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   outstanding <= outstanding + (CNT_W + 1)'(1);
        2'b01:   outstanding <= outstanding - (CNT_W + 1)'(1);
        default: outstanding <= outstanding;
      endcase
      // An ack with nothing outstanding has no owner; it is dropped.
      if (out.ack && fifo_empty) begin
        spurious_ack <= 1'b1;
      end
    end
  end

  // Response steering to the requester at the head of the FIFO.
  assign m0.ack   = pop & ~head_id;
  assign m1.ack   = pop &  head_id;
  assign m0.error = out.error & m0.ack;
  assign m1.error = out.error & m1.ack;
  assign m0.rdata = out.rdata;
  assign m1.rdata = out.rdata;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb/tb_sdram_req_arbiter.sv - directed self-checking bench for sdram_req_arbiter
module tb_sdram_req_arbiter;

  logic       clock;
  logic       reset;
  logic [2:0] outstanding;
  logic       spurious_ack;

  int checks   = 0;
  int failures = 0;

  sdram_req_arbiter_if m0_bus ();
  sdram_req_arbiter_if m1_bus ();
  sdram_req_arbiter_if out_bus ();

  sdram_req_arbiter #(
    .MAX_OUTSTANDING (2),
    .CNT_W           (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .m0           (m0_bus),
    .m1           (m1_bus),
    .out          (out_bus),
    .outstanding  (outstanding),
    .spurious_ack (spurious_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    m0_bus.wr = 4'h0;  m0_bus.rd = 1'b0;  m0_bus.addr = 32'h0;  m0_bus.wdata = 32'h0;
    m1_bus.wr = 4'h0;  m1_bus.rd = 1'b0;  m1_bus.addr = 32'h0;  m1_bus.wdata = 32'h0;
    out_bus.accept = 1'b0;  out_bus.ack = 1'b0;  out_bus.error = 1'b0;  out_bus.rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    // Requests and acks during reset must not produce accept/ack.
    m0_bus.rd = 1'b1;  out_bus.accept = 1'b1;  out_bus.ack = 1'b1;
    step();
    step();
    settle();
    check("rst_m0_accept", m0_bus.accept, 0);
    check("rst_m0_ack", m0_bus.ack, 0);
    check("rst_m1_ack", m1_bus.ack, 0);
    step();
    reset = 1'b0;
    idle();
    settle();
    check("rst_outstanding", outstanding, 0);
    check("rst_spurious", spurious_ack, 0);

    // Contention: round-robin 0,1,0,1 with acks one cycle after accept.
    step();
    m0_bus.rd = 1'b1;  m0_bus.addr = 32'h0000_0100;
    m1_bus.wr = 4'hF;  m1_bus.addr = 32'h0000_0200;  m1_bus.wdata = 32'h5555_AAAA;
    out_bus.accept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2) == 1;
      if (i > 0) out_bus.ack = 1'b1;
      settle();
      check($sformatf("rr%0d_m0_accept", i), m0_bus.accept, !g);
      check($sformatf("rr%0d_m1_accept", i), m1_bus.accept, g);
      check($sformatf("rr%0d_out_addr", i), out_bus.addr, g ? 32'h0000_0200 : 32'h0000_0100);
      if (i > 0) begin
        check($sformatf("rr%0d_m0_ack", i), m0_bus.ack, g);
        check($sformatf("rr%0d_m1_ack", i), m1_bus.ack, !g);
      end
      step();
    end
    idle();
    out_bus.ack = 1'b1;
    settle();
    check("rr_last_m1_ack", m1_bus.ack, 1);
    check("rr_last_m0_ack", m0_bus.ack, 0);
    step();
    out_bus.ack = 1'b0;
    settle();
    check("rr_drained", outstanding, 0);

    // Single requester read with same-cycle accept.
    step();
    m0_bus.rd = 1'b1;  m0_bus.addr = 32'hA000_0010;  out_bus.accept = 1'b1;
    settle();
    check("single_m0_accept", m0_bus.accept, 1);
    check("single_m1_accept", m1_bus.accept, 0);
    check("single_out_rd", out_bus.rd, 1);
    check("single_out_addr", out_bus.addr, 32'hA000_0010);
    step();
    m0_bus.rd = 1'b0;  out_bus.accept = 1'b0;
    settle();
    check("single_outstanding1", outstanding, 1);
    step();
    out_bus.ack = 1'b1;  out_bus.rdata = 32'h1234_5678;
    settle();
    check("single_m0_ack", m0_bus.ack, 1);
    check("single_m0_rdata", m0_bus.rdata, 32'h1234_5678);
    check("single_m1_ack", m1_bus.ack, 0);
    check("single_m0_error", m0_bus.error, 0);
    step();
    out_bus.ack = 1'b0;
    settle();
    check("single_outstanding0", outstanding, 0);
    // Port 1 accepted last in the contention run, then port 0: prio now 1.
    // Bring prio back to 0 with a lone port-1 accept and its ack.
    step();
    m1_bus.rd = 1'b1;  m1_bus.addr = 32'h0000_0F00;  out_bus.accept = 1'b1;
    settle();
    check("prep_m1_accept", m1_bus.accept, 1);
    step();
    idle();
    out_bus.ack = 1'b1;
    settle();
    check("prep_m1_ack", m1_bus.ack, 1);
    step();
    out_bus.ack = 1'b0;

    // Lock: port 1 write stalled 3 cycles while port 0 (favoured) rises.
    m1_bus.wr = 4'hF;  m1_bus.addr = 32'h0000_0300;  m1_bus.wdata = 32'hDEAD_BEEF;
    settle();
    check("lock_c0_out_wr", out_bus.wr, 4'hF);
    check("lock_c0_out_addr", out_bus.addr, 32'h0000_0300);
    check("lock_c0_m1_accept", m1_bus.accept, 0);
    step();
    m0_bus.rd = 1'b1;  m0_bus.addr = 32'h0000_0400;
    settle();
    check("lock_c1_out_addr", out_bus.addr, 32'h0000_0300);
    check("lock_c1_out_wr", out_bus.wr, 4'hF);
    check("lock_c1_out_rd", out_bus.rd, 0);
    check("lock_c1_m0_accept", m0_bus.accept, 0);
    step();
    settle();
    check("lock_c2_out_addr", out_bus.addr, 32'h0000_0300);
    check("lock_c2_out_wdata", out_bus.wdata, 32'hDEAD_BEEF);
    step();
    out_bus.accept = 1'b1;
    settle();
    check("lock_c3_m1_accept", m1_bus.accept, 1);
    check("lock_c3_m0_accept", m0_bus.accept, 0);
    step();
    m1_bus.wr = 4'h0;
    settle();
    check("lock_next_m0_accept", m0_bus.accept, 1);
    check("lock_next_out_rd", out_bus.rd, 1);
    check("lock_next_out_addr", out_bus.addr, 32'h0000_0400);

    // Full FIFO: FIFO holds [m1, m0]; third request must be blocked.
    step();
    m0_bus.addr = 32'h0000_0500;
    settle();
    check("full_outstanding", outstanding, 2);
    check("full_out_rd", out_bus.rd, 0);
    check("full_m0_accept", m0_bus.accept, 0);
    step();
    out_bus.ack = 1'b1;
    settle();
    check("full_ack_m1_ack", m1_bus.ack, 1);
    check("full_ack_m0_ack", m0_bus.ack, 0);
    check("full_ack_out_rd", out_bus.rd, 0);
    check("full_ack_m0_accept", m0_bus.accept, 0);
    step();
    out_bus.ack = 1'b0;
    settle();
    check("full_freed_outstanding", outstanding, 1);
    check("full_freed_out_rd", out_bus.rd, 1);
    check("full_freed_m0_accept", m0_bus.accept, 1);
    // Drain the two port-0 entries.
    step();
    idle();
    out_bus.ack = 1'b1;  out_bus.error = 1'b1;
    settle();
    check("drain0_m0_ack", m0_bus.ack, 1);
    check("drain0_m0_error", m0_bus.error, 1);
    step();
    out_bus.error = 1'b0;
    settle();
    check("drain1_m0_ack", m0_bus.ack, 1);
    check("drain1_m0_error", m0_bus.error, 0);
    step();
    out_bus.ack = 1'b0;
    settle();
    check("drain_outstanding", outstanding, 0);

    // Response ordering with error: accept m0 then m1.
    step();
    m0_bus.rd = 1'b1;  m0_bus.addr = 32'h0000_0600;  out_bus.accept = 1'b1;
    settle();
    check("ord_m0_accept", m0_bus.accept, 1);
    step();
    m0_bus.rd = 1'b0;
    m1_bus.rd = 1'b1;  m1_bus.addr = 32'h0000_0700;
    settle();
    check("ord_m1_accept", m1_bus.accept, 1);
    step();
    idle();
    out_bus.ack = 1'b1;  out_bus.error = 1'b1;  out_bus.rdata = 32'hCAFE_0001;
    settle();
    check("ord0_m0_ack", m0_bus.ack, 1);
    check("ord0_m0_error", m0_bus.error, 1);
    check("ord0_m1_ack", m1_bus.ack, 0);
    check("ord0_m1_error", m1_bus.error, 0);
    step();
    out_bus.error = 1'b0;  out_bus.rdata = 32'hBEEF_0002;
    settle();
    check("ord1_m1_ack", m1_bus.ack, 1);
    check("ord1_m1_error", m1_bus.error, 0);
    check("ord1_m1_rdata", m1_bus.rdata, 32'hBEEF_0002);
    check("ord1_m0_ack", m0_bus.ack, 0);
    step();
    out_bus.ack = 1'b0;
    settle();
    check("ord_outstanding", outstanding, 0);
    check("ord_spurious", spurious_ack, 0);

    // Spurious ack with empty FIFO.
    step();
    out_bus.ack = 1'b1;
    settle();
    check("spur_m0_ack", m0_bus.ack, 0);
    check("spur_m1_ack", m1_bus.ack, 0);
    step();
    out_bus.ack = 1'b0;
    m0_bus.rd = 1'b1;  out_bus.accept = 1'b1;
    settle();
    check("spur_sticky", spurious_ack, 1);
    check("spur_m0_accept", m0_bus.accept, 1);
    // Reset with one request outstanding and prio pointing at port 1.
    step();
    idle();
    reset = 1'b1;
    settle();
    check("prerst_outstanding", outstanding, 1);
    step();
    reset = 1'b0;
    out_bus.ack = 1'b1;
    settle();
    check("postrst_outstanding", outstanding, 0);
    check("postrst_spurious", spurious_ack, 0);
    check("postrst_m0_ack", m0_bus.ack, 0);
    check("postrst_m1_ack", m1_bus.ack, 0);
    step();
    out_bus.ack = 1'b0;
    m0_bus.rd = 1'b1;  m1_bus.rd = 1'b1;  out_bus.accept = 1'b1;
    settle();
    check("postrst_stale_spurious", spurious_ack, 1);
    check("postrst_prio_m0_accept", m0_bus.accept, 1);
    check("postrst_prio_m1_accept", m1_bus.accept, 0);
    step();
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Two-requester arbiter in front of the SDRAM controller core's simple request port: write strobes, read, address, write data, accept, ack, error, read data.
- Shares the single controller between the CPU-side bus adapter (port 0) and a second master (DMA/display, port 1).
- Uses round-robin grant with lock-until-accept.
- An in-order ID FIFO routes each ack, error and read-data response back to the requester that issued the request.
- Adds zero cycles on the request path.

Parameters:
- MAX_OUTSTANDING, 2, depth of the ID FIFO (accepted requests awaiting ack); power of two, 1..8.
- CNT_W, 2, width of outstanding count; must hold MAX_OUTSTANDING.

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  synchronous, active-high reset.
- m0_wr / m1_wr  in  4  byte write strobes from requester 0 / 1; nonzero means write request.
- m0_rd / m1_rd  in  1  read request from requester 0 / 1.
- m0_addr / m1_addr  in  32  request byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_accept / m1_accept  out  1  request taken this cycle.
- m0_ack / m1_ack  out  1  response for this requester.
- m0_error / m1_error  out  1  response error, valid with ack.
- m0_rdata / m1_rdata  out  32  read data, valid with ack.
- out_wr  out  4  write strobes to the controller.
- out_rd  out  1  read to the controller.
- out_addr  out  32  address to the controller.
- out_wdata  out  32  write data to the controller.
- out_accept  in  1  controller accepted the presented request.
- out_ack  in  1  controller response.
- out_error  in  1  controller error, valid with out_ack.
- out_rdata  in  32  controller read data.
- outstanding  out  CNT_W+1  current ID FIFO occupancy.
- spurious_ack  out  1  sticky: out_ack arrived with the FIFO empty.

Behaviour:
- reqN = mN_rd | (|mN_wr). Requesters hold request fields stable until mN_accept.
- Reset state: prio=0 (port 0 favoured), lock=0, FIFO empty, outstanding=0, spurious_ack=0.
- All mN_accept and mN_ack are 0 during reset, regardless of inputs.
- Grant selection:
  - If lock=1, grant=locked_id.
  - Else if only one reqN is set, grant=N.
  - Else if both are set, grant=prio.
  - Else nothing is granted.
- Forwarding:
  - fwd = granted & (outstanding != MAX_OUTSTANDING).
  - When fwd=1, out_* = granted requester's fields.
  - When fwd=0, out_wr=0 and out_rd=0; out_addr and out_wdata still mux the grant (don't-care).
- Accept: mN_accept = fwd & out_accept & (grant==N). Combinational, same cycle.
- Lock:
  - On fwd & !out_accept: lock<=1, locked_id<=grant.
  - On fwd & out_accept: lock<=0.
  - This keeps a presented request unchanged until the controller takes it.
  - If FIFO full while locked, out_rd/out_wr drop to 0 but lock is kept.
- Round-robin: on any accept of port k, prio<=~k. No update otherwise.
- ID FIFO:
  - Push grant on out_accept & fwd.
  - Pop on out_ack when not empty.
  - Simultaneous push and pop: occupancy unchanged; pointers wrap modulo MAX_OUTSTANDING.
  - Full blocks forwarding even if out_ack arrives that cycle. The pop frees space for the next cycle.
- Responses:
  - mN_ack = out_ack & !empty & (head==N).
  - mN_error = out_error & mN_ack.
  - mN_rdata = out_rdata on both ports (qualify with ack).
- out_ack with FIFO empty: dropped, no pop, spurious_ack<=1. Cleared only by reset.
- Reset mid-transaction clears lock, FIFO and prio. Acks from the controller after reset are spurious and set the flag.
- Requester dropping its request while locked is a protocol violation. The arbiter still presents the latched grant's live inputs.

Test Plan:
1. Single requester: m0_rd=1, addr=0xA000_0010, out_accept=1 same cycle -> m0_accept=1 same cycle, outstanding=1. Then out_ack=1, out_rdata=0x1234_5678 -> m0_ack=1, m0_rdata=0x1234_5678, m1_ack=0, outstanding=0.
2. Contention round-robin: both request continuously, out_accept=1 every cycle, immediate acks -> accept order 0,1,0,1. Acks route 0,1,0,1.
3. Lock: m1_wr=0xF, controller stalls out_accept for 3 cycles, m0_rd rises during stall -> out_* stays on m1 all 3 cycles. m1_accept on cycle 4, m0 granted next.
4. Full FIFO (MAX_OUTSTANDING=2): two accepts with no ack -> third request sees out_rd=0, outstanding=2. One out_ack -> next cycle request forwarded.
5. Response ordering/error: accept m0 then m1; out_ack with out_error=1, then out_ack with out_error=0 -> m0_error=1 with m0_ack, then m1_ack=1 with m1_error=0.
6. Spurious/reset: out_ack with FIFO empty -> spurious_ack=1, no mN_ack. Reset with outstanding=1 -> outstanding=0, prio=0, spurious_ack=0.
